// File: rtl/mfp_seg_pkg.sv
// Shared seven-segment definitions: hex glyphs (active-high {g..a}), the
// all-off pattern and the helper that applies pin polarity.
package mfp_seg_pkg;

    typedef logic [6:0] glyph_t;
    typedef logic [7:0] seg_t;    // {dp, g, f, e, d, c, b, a}

    localparam glyph_t SEG_0 = 7'h3F;
    localparam glyph_t SEG_1 = 7'h06;
    localparam glyph_t SEG_2 = 7'h5B;
    localparam glyph_t SEG_3 = 7'h4F;
    localparam glyph_t SEG_4 = 7'h66;
    localparam glyph_t SEG_5 = 7'h6D;
    localparam glyph_t SEG_6 = 7'h7D;
    localparam glyph_t SEG_7 = 7'h07;
    localparam glyph_t SEG_8 = 7'h7F;
    localparam glyph_t SEG_9 = 7'h6F;
    localparam glyph_t SEG_A = 7'h77;
    localparam glyph_t SEG_B = 7'h7C;   // lowercase b
    localparam glyph_t SEG_C = 7'h39;
    localparam glyph_t SEG_D = 7'h5E;   // lowercase d
    localparam glyph_t SEG_E = 7'h79;
    localparam glyph_t SEG_F = 7'h71;

    localparam seg_t SEG_OFF = 8'h00;

    // Convert an active-high segment pattern to the polarity of the pins.
    function automatic seg_t seg_polarity(input seg_t seg, input bit active_low);
        return active_low ? ~seg : seg;
    endfunction

endpackage

// File: rtl/mfp_seven_segment_decoder.sv
// Combinational nibble-to-glyph decoder, active-high {g..a}.
module mfp_seven_segment_decoder
    import mfp_seg_pkg::*;
(
    input  logic [3:0] hex,
    output glyph_t     seg
);

    // Standard hex glyph lookup.
    always_comb begin
        seg = '0;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = '0;
        endcase
    end

endmodule

// File: rtl/mfp_multi_digit_seven_segment_scanner.sv
// Multi-digit seven-segment driver with static or scanned output, frame-
// synchronous shadow registers, leading-zero blanking and PWM dimming.
module mfp_multi_digit_seven_segment_scanner
    import mfp_seg_pkg::*;
#(
    parameter int N_DIGITS       = 6,
    parameter int SCAN_DIV       = 50000,
    parameter int GUARD          = 2,
    parameter int PWM_BITS       = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*N_DIGITS-1:0]   hex_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    lz_blank,
    input  logic                    scan_mode,
    input  logic [PWM_BITS-1:0]     brightness,
    output logic [8*N_DIGITS-1:0]   seg_static,
    output logic [7:0]              seg_scan,
    output logic [N_DIGITS-1:0]     dig_en,
    output logic                    frame_tick
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CNT_W-1:0]    SLOT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]    GUARD_END = CNT_W'(GUARD);
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(N_DIGITS - 1);
    localparam seg_t                SEG_IDLE  = seg_polarity(SEG_OFF, SEG_ACTIVE_LOW);
    localparam logic [N_DIGITS-1:0] DIG_IDLE  = DIG_ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

    logic [CNT_W-1:0]      slot_cnt;
    logic [IDX_W-1:0]      dig_idx;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic                  slot_tick;
    logic                  commit;
    logic                  pwm_on;

    logic [4*N_DIGITS-1:0] shadow_hex;
    logic [N_DIGITS-1:0]   shadow_dp;
    logic                  shadow_lz;
    logic                  shadow_mode;
    logic [PWM_BITS-1:0]   shadow_bright;
    logic [N_DIGITS-1:0]   shadow_blank;
    logic [N_DIGITS-1:0]   blank_next;
    logic                  still_leading;

    glyph_t                glyph [N_DIGITS];
    glyph_t                scan_glyph;
    logic [3:0]            scan_hex;
    logic                  scan_dp;
    logic                  scan_blank;
    logic [N_DIGITS-1:0]   dig_onehot;
    logic [N_DIGITS-1:0]   dig_raw;

    logic [8*N_DIGITS-1:0] seg_static_next;
    seg_t                  seg_scan_next;
    logic [N_DIGITS-1:0]   dig_en_next;

    assign slot_tick = (slot_cnt == SLOT_LAST);
    assign commit    = slot_tick && (dig_idx == IDX_LAST);
    assign pwm_on    = (pwm_cnt < shadow_bright) || (&shadow_bright);

    // Slot timer, digit index and free-running PWM counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            dig_idx  <= '0;
            pwm_cnt  <= '0;
        end else begin
            pwm_cnt  <= pwm_cnt + 1'b1;
            slot_cnt <= slot_tick ? '0 : slot_cnt + 1'b1;
            if (slot_tick) begin
                dig_idx <= (dig_idx == IDX_LAST) ? '0 : dig_idx + 1'b1;
            end
        end
    end

    // Leading-zero mask from the incoming digits; digit 0 always stays visible.
    always_comb begin
        blank_next    = '0;
        still_leading = 1'b1;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            still_leading = still_leading && (hex_in[4*k +: 4] == 4'h0);
            blank_next[k] = lz_blank && still_leading;
        end
    end

    // Shadow registers commit only on the frame boundary so a number never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_hex    <= '0;
            shadow_dp     <= '0;
            shadow_lz     <= 1'b0;
            shadow_mode   <= 1'b0;
            shadow_bright <= '0;
            shadow_blank  <= '0;
            frame_tick    <= 1'b0;
        end else begin
            frame_tick <= commit;
            if (commit) begin
                shadow_hex    <= hex_in;
                shadow_dp     <= dp_in;
                shadow_lz     <= lz_blank;
                shadow_mode   <= scan_mode;
                shadow_bright <= brightness;
                shadow_blank  <= blank_next;
            end
        end
    end

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_dec
        mfp_seven_segment_decoder u_dec (
            .hex (shadow_hex[4*k +: 4]),
            .seg (glyph[k])
        );
    end

    mfp_seven_segment_decoder u_scan_dec (
        .hex (scan_hex),
        .seg (scan_glyph)
    );

    // Select the digit currently owning the shared scan bus.
    always_comb begin
        scan_hex   = '0;
        scan_dp    = 1'b0;
        scan_blank = 1'b0;
        dig_onehot = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (dig_idx == IDX_W'(k)) begin
                scan_hex      = shadow_hex[4*k +: 4];
                scan_dp       = shadow_dp[k];
                scan_blank    = shadow_blank[k];
                dig_onehot[k] = 1'b1;
            end
        end
    end

    // Next pin values; the unused output path of the current mode is held off.
    always_comb begin
        seg_static_next = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            seg_static_next[8*k +: 8] = seg_polarity(
                (!shadow_mode && pwm_on && !shadow_blank[k]) ? {shadow_dp[k], glyph[k]} : SEG_OFF,
                SEG_ACTIVE_LOW);
        end
        seg_scan_next = seg_polarity(
            (shadow_mode && !scan_blank) ? {scan_dp, scan_glyph} : SEG_OFF,
            SEG_ACTIVE_LOW);
        dig_raw     = (shadow_mode && (slot_cnt >= GUARD_END) && pwm_on) ? dig_onehot : '0;
        dig_en_next = DIG_ACTIVE_LOW ? ~dig_raw : dig_raw;
    end

    // Registered outputs; reset drives every pin to its inactive level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_static <= {N_DIGITS{SEG_IDLE}};
            seg_scan   <= SEG_IDLE;
            dig_en     <= DIG_IDLE;
        end else begin
            seg_static <= seg_static_next;
            seg_scan   <= seg_scan_next;
            dig_en     <= dig_en_next;
        end
    end

endmodule

// File: tb/tb_mfp_multi_digit_seven_segment_scanner.sv
// Self-checking bench: frame-level reference model plus directed scenarios.
module tb_mfp_multi_digit_seven_segment_scanner;

    localparam int N     = 6;
    localparam int SD    = 8;
    localparam int G     = 2;
    localparam int PB    = 4;
    localparam int FRAME = N * SD;
    localparam int OW    = 8*N + 8 + N + 1;

    localparam logic [OW-1:0]    OFF_ALL  = {{(OW-1){1'b1}}, 1'b0};
    localparam logic [OW-2:0]    OFF_PINS = {(OW-1){1'b1}};
    localparam logic [8*N-1:0]   ST_OFF   = {(8*N){1'b1}};
    localparam logic [8*N-1:0]   ST_ONES  = {N{8'hF9}};
    localparam logic [8*N-1:0]   ST_TWOS  = {N{8'hA4}};

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [4*N-1:0]    hex_in = '0;
    logic [N-1:0]      dp_in = '0;
    logic              lz_blank = 1'b0;
    logic              scan_mode = 1'b0;
    logic [PB-1:0]     brightness = '0;
    logic [8*N-1:0]    seg_static;
    logic [7:0]        seg_scan;
    logic [N-1:0]      dig_en;
    logic              frame_tick;

    logic [OW-1:0]     obs;
    logic [OW-1:0]     exp_all = OFF_ALL;
    int                errors = 0;
    int                checks = 0;

    logic [6:0] gly [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    assign obs = {seg_static, seg_scan, dig_en, frame_tick};

    always #5 clk = ~clk;

    mfp_multi_digit_seven_segment_scanner #(
        .N_DIGITS       (N),
        .SCAN_DIV       (SD),
        .GUARD          (G),
        .PWM_BITS       (PB),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hex_in     (hex_in),
        .dp_in      (dp_in),
        .lz_blank   (lz_blank),
        .scan_mode  (scan_mode),
        .brightness (brightness),
        .seg_static (seg_static),
        .seg_scan   (seg_scan),
        .dig_en     (dig_en),
        .frame_tick (frame_tick)
    );

    // Reference model: time since release decides slot, digit and PWM phase;
    // the committed picture is latched every FRAME cycles.
    int             t = 0;
    int             m_s, m_d, m_p;
    bit             m_on, m_tick;
    logic [4*N-1:0] m_hex = '0;
    logic [N-1:0]   m_dp = '0;
    logic           m_lz = 1'b0;
    logic           m_mode = 1'b0;
    logic [PB-1:0]  m_br = '0;
    logic [N-1:0]   m_blank;
    logic [7:0]     m_raw;
    logic [8*N-1:0] e_st;
    logic [7:0]     e_sc;
    logic [N-1:0]   e_dg;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            t = 0; m_hex = '0; m_dp = '0; m_lz = 1'b0; m_mode = 1'b0; m_br = '0;
            exp_all = OFF_ALL;
        end else begin
            m_s  = t % SD;
            m_d  = (t / SD) % N;
            m_p  = t % (1 << PB);
            m_on = (m_p < int'(m_br)) || (int'(m_br) == (1 << PB) - 1);
            for (int k = 0; k < N; k++)
                m_blank[k] = m_lz && (k != 0) && ((m_hex >> (4*k)) == 0);
            for (int k = 0; k < N; k++) begin
                m_raw = (!m_mode && m_on && !m_blank[k]) ? {m_dp[k], gly[m_hex[4*k +: 4]]} : 8'h00;
                e_st[8*k +: 8] = ~m_raw;
            end
            m_raw = (m_mode && !m_blank[m_d]) ? {m_dp[m_d], gly[m_hex[4*m_d +: 4]]} : 8'h00;
            e_sc = ~m_raw;
            e_dg = '1;
            if (m_mode && m_s >= G && m_on) e_dg[m_d] = 1'b0;
            m_tick  = (m_s == SD - 1) && (m_d == N - 1);
            exp_all = {e_st, e_sc, e_dg, m_tick};
            if (m_tick) begin
                m_hex = hex_in; m_dp = dp_in; m_lz = lz_blank; m_mode = scan_mode; m_br = brightness;
            end
            t++;
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; hex_in = 24'h123456; dp_in = 6'b000001; lz_blank = 1'b0;
        scan_mode = 1'b0; brightness = 4'hF;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (obs !== OFF_ALL) begin errors++; $display("FAIL reset_hold: got %h expected %h", obs, OFF_ALL); end
        end
        rst_n = 1'b1;
        for (int n = 1; n <= 3*FRAME; n++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_all) begin errors++; $display("FAIL reset_model: cycle %0d got %h expected %h", n, obs, exp_all); end
            checks++;
            if (frame_tick !== (n % FRAME == 0)) begin
                errors++; $display("FAIL frame_tick_timing: cycle %0d got %b expected %b", n, frame_tick, (n % FRAME == 0));
            end
            if (n <= FRAME) begin
                checks++;
                if (obs[OW-1:1] !== OFF_PINS) begin errors++; $display("FAIL dark_first_frame: cycle %0d got %h", n, obs); end
            end
        end
    endtask

    task automatic test_static();
        logic [8*N-1:0] first;
        @(negedge clk);
        first = seg_static;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_all) begin errors++; $display("FAIL static_model: got %h expected %h", obs, exp_all); end
            checks++;
            if (seg_static[7:0] !== 8'h02) begin errors++; $display("FAIL static_digit0: got %h expected 02", seg_static[7:0]); end
            checks++;
            if (seg_static[47:40] !== 8'hF9) begin errors++; $display("FAIL static_digit5: got %h expected f9", seg_static[47:40]); end
            checks++;
            if (seg_static !== first) begin errors++; $display("FAIL static_constant: got %h expected %h", seg_static, first); end
        end
    endtask

    task automatic test_lz_blank();
        bit seen;
        for (int pass = 0; pass < 2; pass++) begin
            hex_in = (pass == 0) ? 24'h000470 : 24'h000000;
            dp_in  = (pass == 0) ? 6'h3F : 6'h00;
            lz_blank = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < 2*FRAME && !seen; i++) begin
                @(negedge clk);
                checks++;
                if (obs !== exp_all) begin errors++; $display("FAIL lz_model: got %h expected %h", obs, exp_all); end
                if (frame_tick) seen = 1'b1;
            end
            checks++;
            if (!seen) begin errors++; $display("FAIL lz_wait_tick: got no tick expected tick"); end
            @(negedge clk);
            checks++;
            if (pass == 0 && seg_static !== {8'hFF, 8'hFF, 8'hFF, 8'h19, 8'h78, 8'h40}) begin
                errors++; $display("FAIL lz_470: got %h expected ffffff197840", seg_static);
            end
            if (pass == 1 && seg_static !== {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}) begin
                errors++; $display("FAIL lz_zero: got %h expected ffffffffffc0", seg_static);
            end
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_tear_free();
        bit seen;
        hex_in = 24'h111111; dp_in = '0; brightness = 4'hF; scan_mode = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2*FRAME && !seen; i++) begin
            @(negedge clk);
            if (frame_tick) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL tear_wait1: got no tick expected tick"); end
        repeat (FRAME/2) @(negedge clk);
        hex_in = 24'h222222;
        seen = 1'b0;
        for (int i = 0; i < 2*FRAME && !seen; i++) begin
            @(negedge clk);
            checks++;
            if (seg_static !== ST_ONES) begin errors++; $display("FAIL tear_old_value: got %h expected %h", seg_static, ST_ONES); end
            checks++;
            if (obs !== exp_all) begin errors++; $display("FAIL tear_model: got %h expected %h", obs, exp_all); end
            if (frame_tick) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL tear_wait2: got no tick expected tick"); end
        @(negedge clk);
        checks++;
        if (seg_static !== ST_TWOS) begin errors++; $display("FAIL tear_new_value: got %h expected %h", seg_static, ST_TWOS); end
    endtask

    task automatic test_scan();
        bit seen;
        int active, s, d;
        logic [N-1:0] dig_on;
        hex_in = 24'h123456; dp_in = 6'b100001; scan_mode = 1'b1; brightness = 4'h8;
        seen = 1'b0;
        for (int i = 0; i < 2*FRAME && !seen; i++) begin
            @(negedge clk);
            if (frame_tick) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL scan_wait: got no tick expected tick"); end
        active = 0;
        for (int j = 1; j <= FRAME; j++) begin
            @(negedge clk);
            s = (j - 1) % SD;
            d = ((j - 1) / SD) % N;
            dig_on = ~dig_en;
            checks++;
            if (obs !== exp_all) begin errors++; $display("FAIL scan_model: got %h expected %h", obs, exp_all); end
            checks++;
            if (dig_on != 0 && dig_on != N'(1 << d)) begin errors++; $display("FAIL scan_onehot: got %h expected digit %0d", dig_en, d); end
            if (s < G) begin
                checks++;
                if (dig_en !== '1) begin errors++; $display("FAIL scan_guard: slot %0d got %h expected 3f", s, dig_en); end
            end
            if (d == 0) begin
                checks++;
                if (seg_scan !== 8'h02) begin errors++; $display("FAIL scan_digit0: got %h expected 02", seg_scan); end
            end
            if (d == 5) begin
                checks++;
                if (seg_scan !== 8'h79) begin errors++; $display("FAIL scan_digit5: got %h expected 79", seg_scan); end
            end
            checks++;
            if (seg_static !== ST_OFF) begin errors++; $display("FAIL scan_static_off: got %h", seg_static); end
            if (dig_on != 0) active++;
        end
        // 6 slots x 6 post-guard cycles, PWM phase lights every other slot.
        checks++;
        if (active != 18) begin errors++; $display("FAIL scan_duty: got %0d expected 18", active); end
    endtask

    task automatic test_brightness_zero();
        bit seen;
        for (int m = 0; m < 2; m++) begin
            hex_in = 24'h8888AB; dp_in = '1; scan_mode = m[0]; brightness = 4'h0;
            seen = 1'b0;
            for (int i = 0; i < 2*FRAME && !seen; i++) begin
                @(negedge clk);
                if (frame_tick) seen = 1'b1;
            end
            checks++;
            if (!seen) begin errors++; $display("FAIL dark_wait: got no tick expected tick"); end
            for (int i = 0; i < FRAME; i++) begin
                @(negedge clk);
                checks++;
                if (m == 0 && obs[OW-1:1] !== OFF_PINS) begin errors++; $display("FAIL dark_static: got %h", obs); end
                if (m == 1 && dig_en !== '1) begin errors++; $display("FAIL dark_scan: got %h expected 3f", dig_en); end
                checks++;
                if (obs !== exp_all) begin errors++; $display("FAIL dark_model: got %h expected %h", obs, exp_all); end
            end
        end
    endtask

    task automatic test_async_reset();
        bit seen;
        hex_in = 24'h9ABCDE; dp_in = '0; scan_mode = 1'b0; brightness = 4'hF;
        seen = 1'b0;
        for (int i = 0; i < 2*FRAME && !seen; i++) begin
            @(negedge clk);
            if (frame_tick) seen = 1'b1;
        end
        repeat (5) @(negedge clk);
        checks++;
        if (obs !== exp_all || seg_static === ST_OFF) begin
            errors++; $display("FAIL areset_prelit: got %h expected %h", obs, exp_all);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== OFF_ALL) begin errors++; $display("FAIL areset_async_clear: got %h expected %h", obs, OFF_ALL); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= FRAME + 2; n++) begin
            @(negedge clk);
            checks++;
            if (frame_tick !== (n == FRAME)) begin
                errors++; $display("FAIL areset_first_tick: cycle %0d got %b expected %b", n, frame_tick, (n == FRAME));
            end
            checks++;
            if (obs !== exp_all) begin errors++; $display("FAIL areset_model: got %h expected %h", obs, exp_all); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 5*FRAME; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_all) begin errors++; $display("FAIL random_model: cycle %0d got %h expected %h", i, obs, exp_all); end
            if ($urandom_range(0, 7) == 0) begin
                hex_in     = 24'($urandom) >> (4 * $urandom_range(0, 6));
                dp_in      = 6'($urandom);
                lz_blank   = 1'($urandom_range(0, 1));
                scan_mode  = 1'($urandom_range(0, 1));
                brightness = 4'($urandom);
            end
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_lz_blank();
        test_tear_free();
        test_scan();
        test_brightness_zero();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
